crc_stream_engine: RTL and testbench

Parametrised, framed CRC engine; the next-generation replacement for the fixed 32-bit CRC-32 block. It accumulates a CRC over a multi-beat frame of `DATA_W`-bit words, supports a partial final word via byte enables, and applies configurable polynomial, init, reflection and output XOR. It presents the result with a byte count on a valid/ready output and sits between the packet datapath and the framing/checksum insertion logic.

---
 rtl/crc_stream_engine.sv | 103 ++++++++++
 tb/tb_crc_stream_engine.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: framed, parametrised CRC over DATA_W-bit beats with byte-enabled final beat
// Ports:
//    clk, reset        - rising-edge clock, synchronous active-low reset
//    data_in           - frame data, byte lane 0 in data_in[7:0]
//    input_valid/ready - input beat handshake
//    input_last        - marks the final beat of a frame
//    byte_en           - valid lanes on the final beat (contiguous from lane 0)
//    crc_out           - finished CRC of the last completed frame
//    frame_bytes       - byte count of that frame, saturating at 16'hFFFF
//    output_valid/ready- result handshake
module crc_stream_engine #(
   parameter int          CRC_W       = 32,
   parameter logic [31:0] POLY        = 32'h04C11DB7,
   parameter logic [31:0] INIT        = 32'hFFFFFFFF,
   parameter logic [31:0] XOR_OUT     = 32'hFFFFFFFF,
   parameter bit          REFLECT_IN  = 1'b1,
   parameter bit          REFLECT_OUT = 1'b1,
   parameter int          DATA_W      = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                input_valid,
   input  logic                input_last,
   input  logic [DATA_W/8-1:0] byte_en,
   output logic                input_ready,
   output logic [CRC_W-1:0]    crc_out,
   output logic [15:0]         frame_bytes,
   output logic                output_valid,
   input  logic                output_ready
);
   localparam int LANES = DATA_W / 8;
   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
   state_t           state;
   logic [CRC_W-1:0] crc_reg;
   logic [CRC_W-1:0] crc_next;
   logic [CRC_W-1:0] crc_final;
   logic [15:0]      count;
   logic [15:0]      count_next;
   logic [16:0]      count_sum;
   logic [7:0]       lanes;
   logic             run;
   logic             accept;
   // Register is kept in normal (MSB-first) form; input reflection only changes bit feed order.
   function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c, input logic [7:0] d);
      logic [CRC_W-1:0] r;
      logic             fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[CRC_W-1] ^ (REFLECT_IN ? d[i] : d[7-i]);
         r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY[CRC_W-1:0] : '0);
      end
      return r;
   endfunction
   function automatic logic [CRC_W-1:0] reverse(input logic [CRC_W-1:0] c);
      logic [CRC_W-1:0] r;
      for (int i = 0; i < CRC_W; i++) r[i] = c[CRC_W-1-i];
      return r;
   endfunction
   // Fold lanes in order; on the last beat stop at the first disabled lane.
   always_comb begin
      crc_next = crc_reg;
      lanes    = '0;
      run      = 1'b1;
      for (int k = 0; k < LANES; k++) begin
         run = run & (!input_last | byte_en[k]);
         if (run) begin
            crc_next = crc_byte(crc_next, data_in[8*k +: 8]);
            lanes    = lanes + 8'd1;
         end
      end
   end
   assign count_sum    = {1'b0, count} + {9'd0, lanes};
   assign count_next   = count_sum[16] ? 16'hFFFF : count_sum[15:0];
   assign crc_final    = (REFLECT_OUT ? reverse(crc_next) : crc_next) ^ XOR_OUT[CRC_W-1:0];
   assign output_valid = (state == DONE);
   assign input_ready  = reset && (!output_valid || output_ready);
   assign accept       = input_valid && input_ready;
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         crc_reg     <= INIT[CRC_W-1:0];
         count       <= '0;
         crc_out     <= '0;
         frame_bytes <= '0;
      end else begin
         if (output_valid && output_ready) state <= IDLE;
         if (accept) begin
            if (input_last) begin
               crc_out     <= crc_final;
               frame_bytes <= count_next;
               crc_reg     <= INIT[CRC_W-1:0];
               count       <= '0;
               state       <= DONE;
            end else begin
               crc_reg <= crc_next;
               count   <= count_next;
               state   <= ACTIVE;
            end
         end
      end
   end
endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: table-driven and scoreboarded checks of crc_stream_engine
module tb_crc_stream_engine;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data_in;
   logic        input_valid;
   logic        input_last;
   logic [3:0]  byte_en;
   logic        input_ready;
   logic [31:0] crc_out;
   logic [15:0] frame_bytes;
   logic        output_valid;
   logic        output_ready;
   logic        c16_ready;
   logic [15:0] c16_crc;
   logic [15:0] c16_bytes;
   logic        c16_valid;

   typedef struct {logic [31:0] crc; logic [15:0] bytes;} exp_t;
   typedef struct {logic [31:0] data; logic [3:0] be; logic [31:0] crc; logic [15:0] bytes;} vec_t;
   exp_t q[$];
   exp_t e_mon;
   vec_t tbl[7];
   int   vectors = 0;
   int   miscompares = 0;
   int   stalls = 0;
   int   valid_cycles = 0;
   int   base;
   logic [31:0] m;
   logic [31:0] d;

   always #5 clk = ~clk;

   crc_stream_engine dut (
      .clk(clk), .reset(reset), .data_in(data_in), .input_valid(input_valid),
      .input_last(input_last), .byte_en(byte_en), .input_ready(input_ready),
      .crc_out(crc_out), .frame_bytes(frame_bytes), .output_valid(output_valid),
      .output_ready(output_ready)
   );

   crc_stream_engine #(
      .CRC_W(16), .POLY(32'h1021), .INIT(32'hFFFF), .XOR_OUT(32'h0),
      .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .DATA_W(32)
   ) u16 (
      .clk(clk), .reset(reset), .data_in(data_in), .input_valid(input_valid),
      .input_last(input_last), .byte_en(byte_en), .input_ready(c16_ready),
      .crc_out(c16_crc), .frame_bytes(c16_bytes), .output_valid(c16_valid),
      .output_ready(output_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reflected-register CRC-32 reference, independent of the engine's formulation.
   function automatic logic [31:0] ref_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] w);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int k = 0; k < 4; k++) c = ref_byte(c, w[8*k +: 8]);
      return ~c;
   endfunction

   task automatic beat(input logic [31:0] dat, input logic l, input logic [3:0] be);
      int n;
      n = 0;
      data_in = dat; input_last = l; byte_en = be; input_valid = 1'b1;
      @(negedge clk);
      while (!input_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n > 0) stalls++;
      if (!input_ready) chk("beat_timeout", {31'd0, input_ready}, 32'd1);
      @(posedge clk);
      #1;
      input_valid = 1'b0;
   endtask

   task automatic frame_123456789();
      beat(32'h34333231, 1'b0, 4'hF);
      beat(32'h38373635, 1'b0, 4'hF);
      beat(32'h00000039, 1'b1, 4'h1);
   endtask

   always @(negedge clk) begin
      if (output_valid) valid_cycles++;
      if (reset && output_valid && output_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            e_mon = q.pop_front();
            chk("crc", crc_out, e_mon.crc);
            chk("bytes", {16'd0, frame_bytes}, {16'd0, e_mon.bytes});
         end
      end
   end

   initial begin
      tbl[0] = '{32'h00000000, 4'hF, 32'h2144DF1C, 16'd4};
      tbl[1] = '{32'h00000000, 4'h0, 32'h00000000, 16'd0};
      tbl[2] = '{32'h00000000, 4'hD, 32'hD202EF8D, 16'd1};
      tbl[3] = '{32'h00000061, 4'h1, 32'hE8B7BE43, 16'd1};
      tbl[4] = '{32'h00636261, 4'h7, 32'h352441C2, 16'd3};
      tbl[5] = '{32'hFFFFFF61, 4'h9, 32'hE8B7BE43, 16'd1};
      tbl[6] = '{32'h12345678, 4'h2, 32'h00000000, 16'd0};
      reset = 1'b0; input_valid = 1'b0; input_last = 1'b0; byte_en = 4'h0;
      data_in = 32'h0; output_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_input_ready", {31'd0, input_ready}, 32'd0);
      chk("rst_output_valid", {31'd0, output_valid}, 32'd0);
      chk("rst_crc_out", crc_out, 32'd0);
      chk("rst_frame_bytes", {16'd0, frame_bytes}, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      // "123456789" through both instances
      q.push_back('{32'hCBF43926, 16'd9});
      frame_123456789();
      chk("latency_valid", {31'd0, output_valid}, 32'd1);
      chk("crc16_value", {16'd0, c16_crc}, 32'h000029B1);
      chk("crc16_bytes", {16'd0, c16_bytes}, 32'd9);
      // single-beat table frames
      for (int i = 0; i < 7; i++) begin
         q.push_back('{tbl[i].crc, tbl[i].bytes});
         beat(tbl[i].data, 1'b1, tbl[i].be);
      end
      repeat (2) @(posedge clk);
      #1;
      // back-to-back single-beat frames
      stalls = 0;
      base = valid_cycles;
      for (int i = 0; i < 101; i++) begin
         d = 32'h12345678 + i;
         q.push_back('{ref_word(d), 16'd4});
         beat(d, 1'b1, 4'hF);
      end
      @(negedge clk);
      #1;
      chk("b2b_stalls", stalls, 32'd0);
      chk("b2b_consecutive", valid_cycles - base, 32'd101);
      // backpressure on the result
      @(posedge clk);
      #1;
      output_ready = 1'b0;
      q.push_back('{32'hCBF43926, 16'd9});
      frame_123456789();
      data_in = 32'hDEADBEEF; input_last = 1'b1; byte_en = 4'hF; input_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("hold_crc", crc_out, 32'hCBF43926);
         chk("hold_ready", {31'd0, input_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      input_valid = 1'b0;
      output_ready = 1'b1;
      q.push_back('{32'hCBF43926, 16'd9});
      frame_123456789();
      // reset in the middle of a frame
      beat(32'h34333231, 1'b0, 4'hF);
      beat(32'h38373635, 1'b0, 4'hF);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_ready", {31'd0, input_ready}, 32'd0);
      chk("midrst_valid", {31'd0, output_valid}, 32'd0);
      reset = 1'b1;
      q.push_back('{32'hCBF43926, 16'd9});
      frame_123456789();
      // byte count saturation: 16385 zero beats = 65540 bytes
      m = 32'hFFFFFFFF;
      for (int i = 0; i < 65540; i++) m = ref_byte(m, 8'h00);
      q.push_back('{~m, 16'hFFFF});
      for (int i = 0; i < 16384; i++) beat(32'h0, 1'b0, 4'hF);
      beat(32'h0, 1'b1, 4'hF);
      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain", q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
